// File: rtl/prog_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prog_loader_pkg                                              |
// | Description : Shared definitions for the program loader: FSM state         |
// |               encoding, default widths matching the processor core, and a  |
// |               helper that classifies the busy states.                      |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package prog_loader_pkg;

    // Loader FSM encoding (3-bit, explicit width)
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Defaults kept in step with the pipelined core's instruction memory
    localparam int c_core_addr_width = 8;
    localparam int c_core_data_width = 16;

    // The loader is busy from the first load cycle until the core stops.
    function automatic logic state_is_busy(input logic [2:0] state);
        return (state == S_LOAD) || (state == S_START) || (state == S_RUN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/prog_loader_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prog_loader_cnt                                              |
// | Description : Saturating up-counter with synchronous clear, count enable   |
// |               and a terminal-count look-ahead flag. The count never        |
// |               exceeds TERMINAL (TERMINAL must be >= 1).                    |
// | Ports       : clk, rst (async active-low)                                  |
// |               i_clr      - clear count to zero (wins over i_en)            |
// |               i_en       - increment by one unless already at TERMINAL     |
// |               o_count    - current count                                   |
// |               o_pre_term - count is one below TERMINAL, so the next        |
// |                            enabled cycle reaches it                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module prog_loader_cnt #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] TERMINAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic             o_pre_term
);

    localparam logic [WIDTH-1:0] c_pre_term = TERMINAL - WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != TERMINAL)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count    = r_count;
    assign o_pre_term = (r_count == c_pre_term);

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prog_loader                                                  |
// | Description : Streams a program image from a valid/ready source into       |
// |               instruction memory, pulses the core's start input, then      |
// |               times the run until the core stops or the timeout expires.   |
// | Ports       : clk, rst (async active-low)                                  |
// |               load_req                 - begin a load (IDLE/DONE only)     |
// |               ld_valid/ld_ready/ld_data/ld_last - image word stream        |
// |               im_wr/im_w_addr/im_w_data - instruction-memory write port    |
// |               im_sel    - 1: loader owns memory, 0: core owns it           |
// |               start     - one-cycle start pulse to the core                |
// |               stop      - core halted                                      |
// |               busy/done/timeout/ovf - status                               |
// |               word_cnt  - words written by the last load                   |
// |               cycle_cnt - cycles from start pulse to stop                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int          ADDR_WIDTH = c_core_addr_width,
    parameter int          DATA_WIDTH = c_core_data_width,
    parameter int          CNT_WIDTH  = 16,
    parameter int unsigned TIMEOUT    = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_req,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  ld_last,
    output logic                  im_wr,
    output logic [ADDR_WIDTH-1:0] im_w_addr,
    output logic [DATA_WIDTH-1:0] im_w_data,
    output logic                  im_sel,
    output logic                  start,
    input  logic                  stop,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic                  ovf,
    output logic [ADDR_WIDTH:0]   word_cnt,
    output logic [CNT_WIDTH-1:0]  cycle_cnt
);

    localparam logic [ADDR_WIDTH-1:0] c_addr_max = '1;
    localparam logic [CNT_WIDTH-1:0]  c_timeout  = CNT_WIDTH'(TIMEOUT);

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_word_cnt;
    logic                  r_ovf;
    logic                  r_timeout;

    logic                  w_hs;
    logic                  w_addr_max;
    logic                  w_clear;
    logic                  w_cnt_clr;
    logic                  w_cnt_en;
    logic                  w_cnt_pre_term;
    logic                  w_run_timeout;

    assign w_hs       = ld_valid && (r_state == S_LOAD);
    assign w_addr_max = (r_addr == c_addr_max);
    // The counter is one below TIMEOUT, so this cycle's increment reaches it;
    // a simultaneous stop takes priority and the run ends normally.
    assign w_run_timeout = (r_state == S_RUN) && w_cnt_pre_term && !stop;

    // ------------------------------------------------------------------------
    // Run-cycle counter: cleared before and at the start pulse, counts every
    // RUN cycle (including the cycle stop is seen), saturates at TIMEOUT.
    // ------------------------------------------------------------------------
    prog_loader_cnt #(
        .WIDTH    (CNT_WIDTH),
        .TERMINAL (c_timeout)
    ) u_run_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_cnt_clr),
        .i_en       (w_cnt_en),
        .o_count    (cycle_cnt),
        .o_pre_term (w_cnt_pre_term)
    );

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and state-decoded outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b0;
        ld_ready    = 1'b0;
        im_sel      = 1'b1;
        start       = 1'b0;
        busy        = state_is_busy(r_state);
        done        = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_clear   = 1'b1;
                w_cnt_clr = 1'b1;
                if (load_req) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                ld_ready = 1'b1;
                if (w_hs) begin
                    if (ld_last) begin
                        w_state_nxt = S_START;
                    end else if (w_addr_max) begin
                        // Image larger than memory: stop without starting the core
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_START: begin
                im_sel      = 1'b0;
                start       = 1'b1;
                w_cnt_clr   = 1'b1;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                im_sel   = 1'b0;
                w_cnt_en = 1'b1;
                if (stop || w_cnt_pre_term) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                // Re-load goes straight to LOAD while applying IDLE's clears
                if (load_req) begin
                    w_clear     = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Write address, word count and sticky status flags
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr     <= '0;
            r_word_cnt <= '0;
            r_ovf      <= 1'b0;
            r_timeout  <= 1'b0;
        end else if (w_clear) begin
            r_addr     <= '0;
            r_word_cnt <= '0;
            r_ovf      <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_hs) begin
                r_word_cnt <= r_word_cnt + (ADDR_WIDTH + 1)'(1);
                // Hold at the top address rather than wrapping onto word 0
                if (!w_addr_max) begin
                    r_addr <= r_addr + ADDR_WIDTH'(1);
                end
                if (w_addr_max && !ld_last) begin
                    r_ovf <= 1'b1;
                end
            end
            if (w_run_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // Write port is driven straight from the handshake; data is gated so the
    // bus stays quiet outside a write.
    assign im_wr     = w_hs;
    assign im_w_addr = r_addr;
    assign im_w_data = w_hs ? ld_data : '0;
    assign word_cnt  = r_word_cnt;
    assign ovf       = r_ovf;
    assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_prog_loader                                               |
// | Description : Self-checking bench for prog_loader. Directed scenarios plus |
// |               randomized loads/runs checked against a transaction-level    |
// |               reference model (expected writes, counts and flags).         |
// | Ports       : none                                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_prog_loader;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int CW    = 8;
    localparam int TO    = 40;
    localparam int DEPTH = 1 << AW;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          load_req = 1'b0;
    logic          ld_valid = 1'b0;
    logic          ld_last  = 1'b0;
    logic          stop     = 1'b0;
    logic [DW-1:0] ld_data  = '0;

    logic          ld_ready;
    logic          im_wr;
    logic [AW-1:0] im_w_addr;
    logic [DW-1:0] im_w_data;
    logic          im_sel;
    logic          start;
    logic          busy;
    logic          done;
    logic          timeout;
    logic          ovf;
    logic [AW:0]   word_cnt;
    logic [CW-1:0] cycle_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int n_start  = 0;

    prog_loader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_req  (load_req),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .im_wr     (im_wr),
        .im_w_addr (im_w_addr),
        .im_w_data (im_w_data),
        .im_sel    (im_sel),
        .start     (start),
        .stop      (stop),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .ovf       (ovf),
        .word_cnt  (word_cnt),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    // Start pulses are tallied mid-cycle; the tally is read only right after
    // a rising edge so it never races with this process.
    always @(negedge clk) begin
        if (start) n_start++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy",     busy,      0);
        chk("rst_done",     done,      0);
        chk("rst_start",    start,     0);
        chk("rst_im_sel",   im_sel,    1);
        chk("rst_ld_ready", ld_ready,  0);
        chk("rst_im_wr",    im_wr,     0);
        chk("rst_addr",     im_w_addr, 0);
        chk("rst_wdata",    im_w_data, 0);
        chk("rst_ovf",      ovf,       0);
        chk("rst_timeout",  timeout,   0);
        chk("rst_word_cnt", word_cnt,  0);
        chk("rst_cyc_cnt",  cycle_cnt, 0);
    endtask

    // One complete transaction: load an image, then (unless it overflows) run
    // the core and stop it after stop_dly cycles (stop_dly <= 0: never stop).
    // vmode: 0 valid every cycle, 1 alternating 1/0, 2 random.
    // rst_k > 0 pulses an asynchronous reset in the rst_k-th run cycle.
    task automatic do_txn(input int len, input bit has_last, input int stop_dly,
                          input int vmode, input bit nominal, input int rst_k);
        logic [DW-1:0] img[$];
        int  n_img, idx, n_wr_exp, end_k, starts0, cyc;
        bit  exp_ovf, exp_to, fin, v;

        // ---- reference model ----
        n_img = (len > DEPTH) ? len : DEPTH;
        for (int i = 0; i < n_img; i++) begin
            img.push_back(nominal ? DW'(16'h1000 + i) : DW'($urandom));
        end
        exp_ovf  = !(has_last && len <= DEPTH);
        n_wr_exp = exp_ovf ? DEPTH : len;
        if (stop_dly >= 1 && stop_dly <= TO) begin
            end_k  = stop_dly;
            exp_to = 1'b0;
        end else begin
            end_k  = TO;
            exp_to = 1'b1;
        end

        // ---- request ----
        starts0  = n_start;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        stop     = 1'b0;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        mid();
        chk("load_ready",    ld_ready,  1);
        chk("load_busy",     busy,      1);
        chk("load_im_sel",   im_sel,    1);
        chk("load_done_clr", done,      0);
        chk("load_ovf_clr",  ovf,       0);
        chk("load_to_clr",   timeout,   0);
        chk("load_wc_clr",   word_cnt,  0);
        chk("load_cc_clr",   cycle_cnt, 0);

        // ---- image transfer ----
        idx = 0;
        fin = 1'b0;
        cyc = 0;
        while (!fin && cyc < 400) begin
            tick();
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            ld_valid = v;
            ld_data  = img[idx];
            ld_last  = has_last && (idx == len - 1);
            load_req = ($urandom_range(0, 3) == 0);  // must be ignored in LOAD
            stop     = 1'($urandom_range(0, 1));     // must be ignored in LOAD
            mid();
            chk("ld_ready",  ld_ready, 1);
            chk("im_wr",     im_wr,    32'(v));
            chk("word_cnt",  word_cnt, idx);
            if (v) begin
                chk("im_w_addr", im_w_addr, idx);
                chk("im_w_data", im_w_data, img[idx]);
                idx++;
                if (ld_last || idx == DEPTH) fin = 1'b1;
            end
            cyc++;
        end
        if (!fin) chk("load_bound", 0, 1);

        tick();
        load_req = 1'b0;
        ld_last  = 1'b0;
        ld_valid = 1'b1;               // source keeps offering a word
        ld_data  = DW'($urandom);
        stop     = 1'($urandom_range(0, 1));

        if (!exp_ovf) begin
            mid();
            chk("start_pulse",  start,    1);
            chk("start_im_sel", im_sel,   0);
            chk("start_ready",  ld_ready, 0);
            chk("start_no_wr",  im_wr,    0);
            chk("start_busy",   busy,     1);
            chk("start_wc",     word_cnt, n_wr_exp);
            for (int k = 1; k <= end_k; k++) begin
                tick();
                stop = (k == stop_dly);
                if (k == rst_k) begin
                    #3;
                    rst = 1'b0;
                    #1;
                    chk_reset_outputs();
                    stop     = 1'b0;
                    ld_valid = 1'b0;
                    tick();
                    rst = 1'b1;
                    return;
                end
                mid();
                chk("run_start",  start,     0);
                chk("run_done",   done,      0);
                chk("run_busy",   busy,      1);
                chk("run_im_sel", im_sel,    0);
                chk("run_no_wr",  im_wr,     0);
                chk("run_cc",     cycle_cnt, k - 1);
            end
            tick();
            stop = 1'b0;
        end
        ld_valid = 1'b0;

        // ---- completion ----
        mid();
        chk("done",        done,      1);
        chk("done_busy",   busy,      0);
        chk("done_im_sel", im_sel,    1);
        chk("done_ovf",    ovf,       32'(exp_ovf));
        chk("done_to",     timeout,   exp_ovf ? 0 : 32'(exp_to));
        chk("done_wc",     word_cnt,  n_wr_exp);
        if (!exp_ovf) chk("done_cc", cycle_cnt, end_k);
        for (int d = 0; d < 3; d++) begin
            tick();
            stop = 1'($urandom_range(0, 1));  // stop outside RUN is ignored
            mid();
            chk("done_hold", done, 1);
            if (!exp_ovf) chk("done_cc_hold", cycle_cnt, end_k);
        end
        tick();
        stop = 1'b0;
        chk("start_count", n_start - starts0, exp_ovf ? 0 : 1);
    endtask

    initial begin
        #12;
        chk_reset_outputs();
        tick();
        rst = 1'b1;

        do_txn(4,     1'b1, 37, 0, 1'b1, 0);  // nominal back-to-back load, stop at 37
        do_txn(6,     1'b1, 5,  1, 1'b0, 0);  // alternating valid
        do_txn(DEPTH, 1'b0, 5,  2, 1'b0, 0);  // overflow, no ld_last
        do_txn(3,     1'b1, 0,  2, 1'b0, 0);  // never stops: timeout
        do_txn(2,     1'b1, TO, 2, 1'b0, 0);  // stop coincides with timeout
        do_txn(DEPTH, 1'b1, 1,  0, 1'b0, 0);  // ld_last at top address
        do_txn(5,     1'b1, 20, 2, 1'b0, 6);  // asynchronous reset mid-run
        do_txn(4,     1'b1, 9,  0, 1'b1, 0);  // full load after reset

        for (int t = 0; t < 12; t++) begin
            int  rl, rs;
            bit  rlast;
            rlast = ($urandom_range(0, 4) != 0);
            rl    = rlast ? int'($urandom_range(1, DEPTH + 3)) : DEPTH;
            rs    = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO + 5));
            do_txn(rl, rlast, rs, 2, 1'b0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Sits directly upstream of the pipelined processor core. Streams a program image from a valid/ready word source into instruction memory, then pulses the core's start input. It monitors the core's stop output and reports run-cycle count, completion and timeout. While loading it owns the instruction-memory write port; the core owns read access only while it runs.

Parameters:
ADDR_WIDTH, 8, instruction-memory address width; the image holds at most 2^ADDR_WIDTH words.
DATA_WIDTH, 16, instruction word width.
CNT_WIDTH, 16, width of the run-cycle counter.
TIMEOUT, 16'hFFFF, maximum run cycles before the run is aborted.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
load_req  input  1  single-cycle request to begin a load; sampled in IDLE and DONE only
ld_valid  input  1  source word valid
ld_ready  output  1  loader accepts a word
ld_data  input  DATA_WIDTH  source instruction word
ld_last  input  1  marks the final word of the image
im_wr  output  1  instruction-memory write enable
im_w_addr  output  ADDR_WIDTH  instruction-memory write address
im_w_data  output  DATA_WIDTH  instruction-memory write data
im_sel  output  1  1 = loader owns instruction memory; 0 = core owns it
start  output  1  one-cycle start pulse to the core
stop  input  1  core halted
busy  output  1  high in LOAD, START and RUN
done  output  1  run finished normally or aborted; held until the next load_req
timeout  output  1  run aborted at TIMEOUT; valid while done=1
ovf  output  1  image exceeded memory without ld_last; valid while done=1
word_cnt  output  ADDR_WIDTH+1  number of words written
cycle_cnt  output  CNT_WIDTH  cycles from the start pulse to stop

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs are 0 except im_sel, which resets to 1. Address and counters clear. Reset mid-load or mid-run aborts the operation immediately; partial memory contents are not cleaned up.
- FSM states: IDLE, LOAD, START, RUN, DONE.
- IDLE:
  - load_req=1 -> LOAD.
  - Clears word_cnt, the address, ovf, timeout and cycle_cnt.
- LOAD:
  - ld_ready=1 and im_sel=1.
  - A handshake is ld_valid & ld_ready. On a handshake, in the same cycle: im_wr=1, im_w_addr=addr, im_w_data=ld_data (combinational from the handshake). Then addr increments and word_cnt increments.
  - Handshake with ld_last=1 -> START.
  - Handshake at addr=2^ADDR_WIDTH-1 with ld_last=0 -> the word is written, ovf=1, then DONE. The core is never started. The address does not wrap.
  - load_req is ignored while in LOAD.
- START:
  - ld_ready=0; im_sel drops to 0 on entry.
  - start=1 for exactly one cycle; cycle_cnt clears.
  - -> RUN.
- RUN:
  - cycle_cnt increments every cycle.
  - stop=1 -> DONE, freezing cycle_cnt at the value of that cycle.
  - cycle_cnt reaches TIMEOUT with stop=0 -> timeout=1, DONE.
  - If stop and TIMEOUT coincide, stop wins: timeout=0.
  - cycle_cnt saturates and never wraps.
- DONE:
  - done=1, busy=0, im_sel=1.
  - load_req=1 -> clears done, ovf and timeout; -> LOAD on the next cycle (through the IDLE clearing actions, done in one step).
- stop asserted outside RUN is ignored.
- ld_valid while ld_ready=0 is not consumed. The source holds its word and must not drop it.
- Latency:
  - Load: one word per cycle at full throughput.
  - ld_last handshake to start pulse: exactly 1 cycle (START state).
  - stop to done=1: 1 cycle.

Decomposition:
- Shared package: the FSM state encoding (3-bit localparams S_IDLE..S_DONE), plus ADDR_WIDTH/DATA_WIDTH defaults aligned with the core's parameters.
- One natural sub-module: prog_loader_cnt, a saturating up-counter with clear, enable and terminal-count compare. It is instantiated for the run-cycle/timeout logic. The address/word counter stays inline.

Test Plan:
- Nominal load: load_req, 4 words 0x1000..0x1003 back-to-back, ld_last on word 4 -> im_wr on 4 consecutive cycles at addr 0..3; word_cnt=4; start pulses 1 cycle after the last handshake; im_sel=0 in RUN.
- Backpressure from source: ld_valid toggles 1,0,1,0 -> only valid cycles write; addresses stay contiguous; no gaps in im_w_addr.
- Run and stop: with ADDR_WIDTH=8, core raises stop 37 cycles after start -> done=1 next cycle; cycle_cnt=37; timeout=0; im_sel=1.
- Timeout: TIMEOUT=20, stop held 0 -> done with timeout=1, cycle_cnt=20. Variant with stop at cycle 20 -> timeout=0.
- Overflow: ADDR_WIDTH=3, 8 words with no ld_last -> 8 writes at addr 0..7; ovf=1; done=1; start never pulses.
- Async reset mid-run: drop rst in RUN between clock edges -> all outputs 0, im_sel=1, immediately. After release, a new load_req performs a full load correctly.
